mrsc_decoder: RTL and testbench

Pipelined decoder for the 32-bit MRSC (Matrix Region Selection Code) codeword produced by `mrsc_encoder`. It recomputes check and parity syndromes and corrects any error confined to one 2x2 data region. It flags uncorrectable patterns and keeps saturating error counters. It sits on the read path between the protected storage and the consumer, using a valid/ready stream interface on both sides.

---
 rtl/mrsc_decoder.sv | 159 +++++++++++++++
 tb/tb_mrsc_decoder.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/mrsc_decoder.sv
// Two-stage MRSC decoder: S1 registers the codeword and syndromes, and S2 registers the corrected data and flags.
// Single-region errors are corrected, uncorrectable patterns are flagged, and saturating counters track both outcomes.
module mrsc_decoder (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_word,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic        out_err,
  output logic        out_corr,
  output logic        out_uncorr,
  input  logic        clr_counts,
  output logic [15:0] corr_count,
  output logic [15:0] uncorr_count
);

  typedef enum logic [2:0] {
    PAIR_CLEAN,
    PAIR_NOFIX,
    PAIR_FIX_A,
    PAIR_FIX_B,
    PAIR_BAD
  } pair_e;

  // Regions are {upper-left, upper-right, lower-left, lower-right} taken from data = {r0, r1, r2, r3}.
  function automatic logic [3:0] di1(input logic [15:0] d);
    return {d[15], d[14], d[11], d[10]};
  endfunction
  function automatic logic [3:0] di2(input logic [15:0] d);
    return {d[13], d[12], d[9], d[8]};
  endfunction
  function automatic logic [3:0] di3(input logic [15:0] d);
    return {d[7], d[6], d[3], d[2]};
  endfunction
  function automatic logic [3:0] di4(input logic [15:0] d);
    return {d[5], d[4], d[1], d[0]};
  endfunction

  function automatic logic [1:0] rp(input logic [3:0] s);
    return {s[3] ^ s[2], s[1] ^ s[0]};
  endfunction

  function automatic logic [15:0] join_regions(input logic [3:0] a, input logic [3:0] b,
                                               input logic [3:0] c, input logic [3:0] e);
    return {a[3:2], b[3:2], a[1:0], b[1:0], c[3:2], e[3:2], c[1:0], e[1:0]};
  endfunction

  function automatic pair_e classify(input logic [3:0] sx, input logic [1:0] spa,
                                     input logic [1:0] spb);
    pair_e r;
    r = PAIR_BAD;
    if (sx == 4'd0) begin
      if (spa == 2'd0 && spb == 2'd0)            r = PAIR_CLEAN;
      else if ((spa == 2'd0) != (spb == 2'd0))   r = PAIR_NOFIX;
    end else begin
      if (spa == 2'd0 && spb == 2'd0)            r = PAIR_NOFIX;
      else if (spb == 2'd0 && spa == rp(sx))     r = PAIR_FIX_A;
      else if (spa == 2'd0 && spb == rp(sx))     r = PAIR_FIX_B;
    end
    return r;
  endfunction

  // Stage-1 syndromes computed straight from the incoming word.
  logic [15:0] in_data;
  logic [3:0]  sx13_c, sx24_c;
  logic [7:0]  sp_c;
  logic        en;

  assign in_data = in_word[31:16];
  assign sx13_c  = in_word[15:12] ^ di1(in_data) ^ di3(in_data);
  assign sx24_c  = in_word[11:8]  ^ di2(in_data) ^ di4(in_data);
  assign sp_c    = {in_word[7:6] ^ rp(di1(in_data)), in_word[5:4] ^ rp(di2(in_data)),
                    in_word[3:2] ^ rp(di3(in_data)), in_word[1:0] ^ rp(di4(in_data))};

  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  logic        s1_valid;
  logic [15:0] s1_data;
  logic [3:0]  s1_sx13, s1_sx24;
  logic [7:0]  s1_sp;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_sx13  <= '0;
      s1_sx24  <= '0;
      s1_sp    <= '0;
    end else if (en) begin
      s1_valid <= in_valid;
      s1_data  <= in_data;
      s1_sx13  <= sx13_c;
      s1_sx24  <= sx24_c;
      s1_sp    <= sp_c;
    end
  end

  pair_e       pair13, pair24;
  logic [3:0]  r1, r2, r3, r4;
  logic [15:0] fix_data;
  logic        err_c, corr_c, uncorr_c;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    pair13   = classify(s1_sx13, s1_sp[7:6], s1_sp[3:2]);
    pair24   = classify(s1_sx24, s1_sp[5:4], s1_sp[1:0]);
    r1       = di1(s1_data);
    r2       = di2(s1_data);
    r3       = di3(s1_data);
    r4       = di4(s1_data);
    if (pair13 == PAIR_FIX_A) r1 = r1 ^ s1_sx13;
    if (pair13 == PAIR_FIX_B) r3 = r3 ^ s1_sx13;
    if (pair24 == PAIR_FIX_A) r2 = r2 ^ s1_sx24;
    if (pair24 == PAIR_FIX_B) r4 = r4 ^ s1_sx24;
    uncorr_c = (pair13 == PAIR_BAD) || (pair24 == PAIR_BAD);
    corr_c   = !uncorr_c && ((pair13 != PAIR_CLEAN) || (pair24 != PAIR_CLEAN));
    err_c    = (s1_sx13 != 4'd0) || (s1_sx24 != 4'd0) || (s1_sp != 8'd0);
    // An uncorrectable word passes through raw, without a partial fix on the other pair.
    fix_data = uncorr_c ? s1_data : join_regions(r1, r2, r3, r4);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_err    <= 1'b0;
      out_corr   <= 1'b0;
      out_uncorr <= 1'b0;
    end else if (en) begin
      out_valid  <= s1_valid;
      out_data   <= fix_data;
      out_err    <= err_c;
      out_corr   <= corr_c;
      out_uncorr <= uncorr_c;
    end
  end

  logic out_fire;
  assign out_fire = out_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      corr_count   <= '0;
      uncorr_count <= '0;
    end else if (clr_counts) begin
      corr_count   <= '0;
      uncorr_count <= '0;
    end else if (out_fire) begin
      if (out_corr && corr_count != 16'hFFFF)     corr_count   <= corr_count + 16'd1;
      if (out_uncorr && uncorr_count != 16'hFFFF) uncorr_count <= uncorr_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_mrsc_decoder.sv
// Directed bench for mrsc_decoder: a vector table for decode results, plus sequences for
// streaming with a stall, reset while words are in flight, counter clear and counter saturation.
module tb_mrsc_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_word;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_err;
  logic        out_corr;
  logic        out_uncorr;
  logic        clr_counts;
  logic [15:0] corr_count;
  logic [15:0] uncorr_count;

  mrsc_decoder dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_word      (in_word),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_err      (out_err),
    .out_corr     (out_corr),
    .out_uncorr   (out_uncorr),
    .clr_counts   (clr_counts),
    .corr_count   (corr_count),
    .uncorr_count (uncorr_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] word;
    logic [15:0] data;
    logic        err;
    logic        corr;
    logic        uncorr;
    logic [15:0] cc;
    logic [15:0] uc;
  } vec_t;

  vec_t vecs[11];
  int   passed = 0;
  int   total  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h, expected %h", name, act, exp);
    else passed++;
  endtask

  task automatic send_vec(input int i);
    @(negedge clk);
    in_valid = 1'b1;
    in_word  = vecs[i].word;
    @(negedge clk);
    in_valid = 1'b0;
    check($sformatf("v%0d_latency", i), {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    check($sformatf("v%0d_valid", i),  {31'd0, out_valid},  32'd1);
    check($sformatf("v%0d_data", i),   {16'd0, out_data},   {16'd0, vecs[i].data});
    check($sformatf("v%0d_err", i),    {31'd0, out_err},    {31'd0, vecs[i].err});
    check($sformatf("v%0d_corr", i),   {31'd0, out_corr},   {31'd0, vecs[i].corr});
    check($sformatf("v%0d_uncorr", i), {31'd0, out_uncorr}, {31'd0, vecs[i].uncorr});
    @(negedge clk);
    check($sformatf("v%0d_ccount", i), {16'd0, corr_count},   {16'd0, vecs[i].cc});
    check($sformatf("v%0d_ucount", i), {16'd0, uncorr_count}, {16'd0, vecs[i].uc});
  endtask

  task automatic send_word(input logic [31:0] w);
    @(negedge clk);
    in_valid = 1'b1;
    in_word  = w;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  logic [31:0] s_words[4];
  logic [15:0] s_exp[4];

  initial begin
    int          sent;
    int          recv;
    int          extra;
    logic        stalled;
    logic [15:0] held;

    rst = 1'b1; in_valid = 1'b0; in_word = '0; out_ready = 1'b1; clr_counts = 1'b0;

    //           word          data     err   corr  uncorr cc      uc
    vecs[0]  = '{32'h80FA6E85, 16'h80FA, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0};
    vecs[1]  = '{32'h00FA6E85, 16'h80FA, 1'b1, 1'b1, 1'b0, 16'd1, 16'd0};
    vecs[2]  = '{32'h80FA6E84, 16'h80FA, 1'b1, 1'b1, 1'b0, 16'd2, 16'd0};
    vecs[3]  = '{32'h80FA6F85, 16'h80FA, 1'b1, 1'b1, 1'b0, 16'd3, 16'd0};
    vecs[4]  = '{32'h007A6E85, 16'h007A, 1'b1, 1'b0, 1'b1, 16'd3, 16'd1};
    vecs[5]  = '{32'h80FB6E85, 16'h80FA, 1'b1, 1'b1, 1'b0, 16'd4, 16'd1};
    vecs[6]  = '{32'h80F26E85, 16'h80FA, 1'b1, 1'b1, 1'b0, 16'd5, 16'd1};
    vecs[7]  = '{32'h80FAEEC5, 16'h80FA, 1'b1, 1'b0, 1'b1, 16'd5, 16'd2};
    vecs[8]  = '{32'h80FA6EC5, 16'h80FA, 1'b1, 1'b1, 1'b0, 16'd6, 16'd2};
    vecs[9]  = '{32'h12341A34, 16'h1234, 1'b0, 1'b0, 1'b0, 16'd6, 16'd2};
    vecs[10] = '{32'h32341A34, 16'h1234, 1'b1, 1'b1, 1'b0, 16'd7, 16'd2};

    s_words = '{32'h80FA6E85, 32'h12341A34, 32'h00000000, 32'hFFFF0000};
    s_exp   = '{16'h80FA, 16'h1234, 16'h0000, 16'hFFFF};

    #12;
    check("rst_valid",  {31'd0, out_valid},  32'd0);
    check("rst_data",   {16'd0, out_data},   32'd0);
    check("rst_flags",  {29'd0, out_err, out_corr, out_uncorr}, 32'd0);
    check("rst_counts", {corr_count, uncorr_count}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);

    for (int i = 0; i < 11; i++) send_vec(i);

    // Back-to-back stream with a three-cycle output stall.
    sent = 0; recv = 0; stalled = 1'b0; held = '0;
    for (int cyc = 0; cyc < 40 && recv < 4; cyc++) begin
      @(negedge clk);
      if (stalled) begin
        check("stall_valid", {31'd0, out_valid}, 32'd1);
        check("stall_hold",  {16'd0, out_data},  {16'd0, held});
      end
      out_ready = !(cyc >= 3 && cyc <= 5);
      in_valid  = (sent < 4);
      in_word   = (sent < 4) ? s_words[sent] : 32'd0;
      #1;
      if (in_valid && in_ready) sent++;
      if (out_valid && out_ready) begin
        check($sformatf("stream_data%0d", recv), {16'd0, out_data}, {16'd0, s_exp[recv]});
        recv++;
      end
      stalled = out_valid && !out_ready;
      if (stalled) held = out_data;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("stream_received", recv, 32'd4);
    extra = 0;
    repeat (3) begin
      @(negedge clk);
      if (out_valid) extra++;
    end
    check("stream_no_dup", extra, 32'd0);

    // Reset with two words in flight; counters are nonzero from the table.
    @(negedge clk);
    in_valid = 1'b1; in_word = 32'h00FA6E85;
    @(negedge clk);
    in_word = 32'h007A6E85;
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("midrst_valid",  {31'd0, out_valid}, 32'd0);
    check("midrst_counts", {corr_count, uncorr_count}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    extra = 0;
    repeat (3) begin
      @(negedge clk);
      if (out_valid) extra++;
    end
    check("midrst_discard", extra, 32'd0);

    // Plain counter clear with no handshake in the same cycle.
    send_word(32'h00FA6E85);
    check("clr_pre", {16'd0, corr_count}, 32'd1);
    @(negedge clk);
    clr_counts = 1'b1;
    @(negedge clk);
    clr_counts = 1'b0;
    check("clr_post", {16'd0, corr_count}, 32'd0);

    // Drive the corrected count to 16'hFFFE, then past saturation.
    @(negedge clk);
    in_valid = 1'b1; in_word = 32'h00FA6E85;
    repeat (65534) @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("sat_fffe", {16'd0, corr_count}, 32'h0000FFFE);
    in_valid = 1'b1;
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("sat_ffff",   {16'd0, corr_count},   32'h0000FFFF);
    check("sat_uncorr", {16'd0, uncorr_count}, 32'd0);

    // Clear in the same cycle as a corrected output handshake.
    @(negedge clk);
    in_valid = 1'b1; in_word = 32'h00FA6E85;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check("clr_race_pre", {30'd0, out_valid, out_corr}, 32'd3);
    clr_counts = 1'b1;
    @(negedge clk);
    clr_counts = 1'b0;
    check("clr_race_post", {16'd0, corr_count}, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
